// File: rtl/axi_rd_vc_if.sv
// AXI read slave that serves per-VC receive buffers, occupancy CSRs and an error region.
// Reads are queued in a small outstanding-request FIFO and streamed as bursts by a two-state FSM.

module axi_rd_vc_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              empty_o,
  output logic              full_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
endmodule

module axi_rd_vc_if #(
  parameter int N_VC      = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int BUF_DEPTH = 4,
  parameter int OT_DEPTH  = 2,
  parameter int RD_BASE   = 'h1000,
  parameter int CSR_BASE  = 'h1100,
  localparam int VC_W     = (N_VC > 1) ? $clog2(N_VC) : 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              arvalid_i,
  output logic              arready_o,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic [7:0]        arlen_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [VC_W-1:0]   in_vc_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic [N_VC-1:0]   vc_avail_o
);
  localparam int OCC_W   = $clog2(BUF_DEPTH + 1);
  localparam int OT_PW   = $clog2(OT_DEPTH);
  localparam int OT_CW   = $clog2(OT_DEPTH + 1);
  localparam bit VC_POW2 = ((1 << VC_W) == N_VC);

  typedef enum logic [1:0] {REG_VCBUF, REG_CSR, REG_ERR} region_e;
  typedef enum logic {S_IDLE, S_BURST} state_e;
  typedef struct packed {
    region_e         region;
    logic [VC_W-1:0] vc;
    logic [7:0]      len;
  } ot_ent_t;

  // VC buffers
  logic [N_VC-1:0]              push_vc, pop_vc, empty, full;
  logic [N_VC-1:0][DATA_W-1:0]  head_data;
  logic [N_VC-1:0][OCC_W-1:0]   occ;
  logic                         in_vc_ok;

  assign in_vc_ok   = VC_POW2 ? 1'b1 : (32'(in_vc_i) < N_VC);
  assign in_ready_o = in_vc_ok ? ~full[in_vc_i] : 1'b1;
  assign vc_avail_o = ~empty;

  for (genvar i = 0; i < N_VC; i++) begin : g_vc
    assign push_vc[i] = in_valid_i & in_vc_ok & (in_vc_i == VC_W'(i)) & ~full[i];
    axi_rd_vc_buf #(.DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) u_buf (
      .clk    (clk),
      .arst   (arst),
      .push_i (push_vc[i]),
      .pop_i  (pop_vc[i]),
      .data_i (in_data_i),
      .head_o (head_data[i]),
      .cnt_o  (occ[i]),
      .empty_o(empty[i]),
      .full_o (full[i])
    );
  end

  // Address decode; anything not an exact word match lands in ERR
  ot_ent_t dec;
  always_comb begin
    dec.region = REG_ERR;
    dec.vc     = '0;
    dec.len    = arlen_i;
    for (int i = 0; i < N_VC; i++) begin
      if (araddr_i == ADDR_W'(RD_BASE + 4 * i)) begin
        dec.region = REG_VCBUF;
        dec.vc     = VC_W'(i);
      end
      if (araddr_i == ADDR_W'(CSR_BASE + 4 * i)) begin
        dec.region = REG_CSR;
        dec.vc     = VC_W'(i);
      end
    end
  end

  // Outstanding-request FIFO
  ot_ent_t          ot_mem_q [OT_DEPTH];
  ot_ent_t          head;
  logic [OT_PW-1:0] ot_wr_q, ot_rd_q;
  logic [OT_CW-1:0] ot_cnt_q;
  logic             ot_full, ot_empty, ar_push, ot_pop;

  assign ot_full   = (ot_cnt_q == OT_CW'(OT_DEPTH));
  assign ot_empty  = (ot_cnt_q == '0);
  assign arready_o = ~ot_full;
  assign ar_push   = arvalid_i & ~ot_full;
  assign head      = ot_mem_q[ot_rd_q];

  always_ff @(posedge clk) begin
    if (ar_push) ot_mem_q[ot_wr_q] <= dec;
  end

  // Read FSM
  state_e           state_q, state_d;
  logic [7:0]       beat_q, beat_d;
  logic             csr_held_q, csr_held_d;
  logic [OCC_W-1:0] csr_hold_q, csr_hold_d;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    csr_held_d = csr_held_q;
    csr_hold_d = csr_hold_q;
    rvalid_o   = 1'b0;
    rdata_o    = '0;
    rresp_o    = 2'b00;
    rlast_o    = 1'b0;
    pop_vc     = '0;
    ot_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!ot_empty) begin
          state_d = S_BURST;
          beat_d  = '0;
        end
      end
      S_BURST: begin
        case (head.region)
          REG_VCBUF: begin
            if (!empty[head.vc]) begin
              rvalid_o = 1'b1;
              rdata_o  = head_data[head.vc];
            end
          end
          REG_CSR: begin
            // Occupancy can move under a stalled beat, so freeze what was first shown
            rvalid_o = 1'b1;
            rdata_o  = DATA_W'(csr_held_q ? csr_hold_q : occ[head.vc]);
          end
          default: begin
            rvalid_o = 1'b1;
            rresp_o  = 2'b10;
          end
        endcase
        rlast_o = rvalid_o & (beat_q == head.len);
        if (rvalid_o && rready_i) begin
          csr_held_d = 1'b0;
          if (head.region == REG_VCBUF) pop_vc[head.vc] = 1'b1;
          if (rlast_o) begin
            state_d = S_IDLE;
            beat_d  = '0;
            ot_pop  = 1'b1;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end else if (rvalid_o && head.region == REG_CSR && !csr_held_q) begin
          csr_held_d = 1'b1;
          csr_hold_d = occ[head.vc];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      csr_held_q <= 1'b0;
      csr_hold_q <= '0;
      ot_wr_q    <= '0;
      ot_rd_q    <= '0;
      ot_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      csr_held_q <= csr_held_d;
      csr_hold_q <= csr_hold_d;
      if (ar_push) ot_wr_q <= ot_wr_q + 1'b1;
      if (ot_pop)  ot_rd_q <= ot_rd_q + 1'b1;
      case ({ar_push, ot_pop})
        2'b10:   ot_cnt_q <= ot_cnt_q + 1'b1;
        2'b01:   ot_cnt_q <= ot_cnt_q - 1'b1;
        default: ot_cnt_q <= ot_cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_vc_if.sv
// Directed bench for axi_rd_vc_if at default parameters (2 VCs, depth 4, OT depth 2).
module tb_axi_rd_vc_if;
  logic        clk, arst;
  logic        arvalid_i, arready_o;
  logic [15:0] araddr_i;
  logic [7:0]  arlen_i;
  logic        rvalid_o, rready_i, rlast_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        in_valid_i, in_ready_o;
  logic [0:0]  in_vc_i;
  logic [31:0] in_data_i;
  logic [1:0]  vc_avail_o;

  int total = 0;
  int bad   = 0;

  axi_rd_vc_if dut (
    .clk(clk), .arst(arst),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arlen_i(arlen_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_vc_i(in_vc_i), .in_data_i(in_data_i),
    .vc_avail_o(vc_avail_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: all start and end just after a falling edge.
  task automatic push(input logic [0:0] vc, input logic [31:0] d);
    in_valid_i = 1'b1; in_vc_i = vc; in_data_i = d;
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic do_ar(input logic [15:0] a, input logic [7:0] l);
    int n = 0;
    arvalid_i = 1'b1; araddr_i = a; arlen_i = l;
    while (arready_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL ar_timeout addr=%h", a);
    end
    @(negedge clk);
    arvalid_i = 1'b0;
  endtask

  task automatic get_beat(output bit ok, output logic [31:0] d, output logic [1:0] r, output logic l);
    int n = 0;
    while (rvalid_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    ok = (rvalid_o === 1'b1); d = rdata_o; r = rresp_o; l = rlast_o;
    rready_i = 1'b1;
    @(negedge clk);
    rready_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({arready_o, rvalid_o, rlast_o, rdata_o, rresp_o, in_ready_o, vc_avail_o} !== {1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 2'b00}) begin
      bad++; $display("FAIL reset_in arready=%b rvalid=%b rdata=%h in_ready=%b avail=%b exp 1 0 0 1 00",
                      arready_o, rvalid_o, rdata_o, in_ready_o, vc_avail_o);
    end
    arst = 1'b0;
    @(negedge clk);
    total++;
    if ({arready_o, rvalid_o, in_ready_o, vc_avail_o} !== {1'b1, 1'b0, 1'b1, 2'b00}) begin
      bad++; $display("FAIL reset_out arready=%b rvalid=%b in_ready=%b avail=%b exp 1 0 1 00",
                      arready_o, rvalid_o, in_ready_o, vc_avail_o);
    end
  endtask

  task automatic test_vcbuf();
    logic [31:0] exp [3] = '{32'hA, 32'hB, 32'hC};
    bit ok; logic [31:0] d; logic [1:0] r; logic l;
    for (int i = 0; i < 3; i++) push(1'b1, exp[i]);
    total++;
    if (vc_avail_o !== 2'b10) begin bad++; $display("FAIL vcbuf_avail got=%b exp=10", vc_avail_o); end
    do_ar(16'h1004, 8'd2);
    for (int i = 0; i < 3; i++) begin
      get_beat(ok, d, r, l);
      total++;
      if ({ok, d, r, l} !== {1'b1, exp[i], 2'b00, 1'(i == 2)}) begin
        bad++; $display("FAIL vcbuf_beat%0d ok=%b data=%h resp=%b last=%b exp data=%h", i, ok, d, r, l, exp[i]);
      end
    end
    total++;
    if ({vc_avail_o, rvalid_o} !== {2'b00, 1'b0}) begin
      bad++; $display("FAIL vcbuf_after avail=%b rvalid=%b exp 00 0", vc_avail_o, rvalid_o);
    end
  endtask

  task automatic test_stall();
    bit ok, seen; logic [31:0] d; logic [1:0] r; logic l;
    seen = 1'b0;
    do_ar(16'h1000, 8'd1);
    repeat (5) begin @(negedge clk); if (rvalid_o !== 1'b0 || rlast_o !== 1'b0) seen = 1'b1; end
    total++;
    if (seen) begin bad++; $display("FAIL stall_empty rvalid seen=1 exp 0"); end
    push(1'b0, 32'hD);
    push(1'b0, 32'hE);
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, r, l} !== {1'b1, 32'hD, 2'b00, 1'b0}) begin
      bad++; $display("FAIL stall_beatD ok=%b data=%h resp=%b last=%b exp 1 D 00 0", ok, d, r, l);
    end
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, r, l} !== {1'b1, 32'hE, 2'b00, 1'b1}) begin
      bad++; $display("FAIL stall_beatE ok=%b data=%h resp=%b last=%b exp 1 E 00 1", ok, d, r, l);
    end
  endtask

  task automatic test_csr_full();
    logic [31:0] exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    bit ok; logic [31:0] d; logic [1:0] r; logic l;
    for (int i = 0; i < 4; i++) push(1'b0, exp[i]);
    in_vc_i = 1'b0; #1;
    total++;
    if (in_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready_vc0 got=%b exp=0", in_ready_o); end
    in_vc_i = 1'b1; #1;
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("FAIL full_ready_vc1 got=%b exp=1", in_ready_o); end
    @(negedge clk);
    do_ar(16'h1100, 8'd0);
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, r, l} !== {1'b1, 32'd4, 2'b00, 1'b1}) begin
      bad++; $display("FAIL csr_occ4 ok=%b data=%h resp=%b last=%b exp 1 4 00 1", ok, d, r, l);
    end
    // Offer a flit to the full VC across the first pop edge: it must be refused.
    in_valid_i = 1'b1; in_vc_i = 1'b0; in_data_i = 32'hFF;
    do_ar(16'h1000, 8'd3);
    for (int i = 0; i < 4; i++) begin
      get_beat(ok, d, r, l);
      in_valid_i = 1'b0;
      total++;
      if ({ok, d, r, l} !== {1'b1, exp[i], 2'b00, 1'(i == 3)}) begin
        bad++; $display("FAIL drain_beat%0d ok=%b data=%h last=%b exp data=%h", i, ok, d, l, exp[i]);
      end
    end
    total++;
    if (vc_avail_o !== 2'b00) begin bad++; $display("FAIL no_bypass avail=%b exp=00", vc_avail_o); end
  endtask

  task automatic test_push_pop();
    bit ok; logic [31:0] d; logic [1:0] r; logic l;
    push(1'b1, 32'h51);
    push(1'b1, 32'h52);
    do_ar(16'h1004, 8'd2);
    @(negedge clk);
    total++;
    if ({rvalid_o, rdata_o} !== {1'b1, 32'h51}) begin
      bad++; $display("FAIL pp_first rvalid=%b data=%h exp 1 51", rvalid_o, rdata_o);
    end
    in_valid_i = 1'b1; in_vc_i = 1'b1; in_data_i = 32'h53; rready_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0; rready_i = 1'b0;
    total++;
    if (vc_avail_o !== 2'b10) begin bad++; $display("FAIL pp_avail got=%b exp=10", vc_avail_o); end
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, l} !== {1'b1, 32'h52, 1'b0}) begin bad++; $display("FAIL pp_second data=%h last=%b exp 52 0", d, l); end
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, l} !== {1'b1, 32'h53, 1'b1}) begin bad++; $display("FAIL pp_third data=%h last=%b exp 53 1", d, l); end
  endtask

  task automatic test_err();
    bit ok; logic [31:0] d; logic [1:0] r; logic l;
    do_ar(16'h2000, 8'd3);
    for (int b = 0; b < 4; b++) begin
      if (b == 1) begin
        repeat (2) begin
          @(negedge clk);
          total++;
          if ({rvalid_o, rdata_o, rresp_o, rlast_o} !== {1'b1, 32'h0, 2'b10, 1'b0}) begin
            bad++; $display("FAIL err_hold rvalid=%b data=%h resp=%b last=%b exp 1 0 10 0", rvalid_o, rdata_o, rresp_o, rlast_o);
          end
        end
      end
      get_beat(ok, d, r, l);
      total++;
      if ({ok, d, r, l} !== {1'b1, 32'h0, 2'b10, 1'(b == 3)}) begin
        bad++; $display("FAIL err_beat%0d ok=%b data=%h resp=%b last=%b", b, ok, d, r, l);
      end
    end
  endtask

  task automatic test_decode();
    logic [15:0] bad_addr [4] = '{16'h1002, 16'h1008, 16'h1108, 16'h1101};
    bit ok; logic [31:0] d; logic [1:0] r; logic l;
    for (int i = 0; i < 4; i++) begin
      do_ar(bad_addr[i], 8'd0);
      get_beat(ok, d, r, l);
      total++;
      if ({ok, d, r, l} !== {1'b1, 32'h0, 2'b10, 1'b1}) begin
        bad++; $display("FAIL decode_err addr=%h data=%h resp=%b last=%b exp 0 10 1", bad_addr[i], d, r, l);
      end
    end
    push(1'b1, 32'h61);
    push(1'b1, 32'h62);
    do_ar(16'h1104, 8'd0);
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, r, l} !== {1'b1, 32'd2, 2'b00, 1'b1}) begin
      bad++; $display("FAIL decode_csr1 data=%h resp=%b last=%b exp 2 00 1", d, r, l);
    end
    do_ar(16'h1004, 8'd1);
    get_beat(ok, d, r, l);
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, l, vc_avail_o} !== {1'b1, 32'h62, 1'b1, 2'b00}) begin
      bad++; $display("FAIL decode_drain data=%h last=%b avail=%b exp 62 1 00", d, l, vc_avail_o);
    end
  endtask

  task automatic test_latency();
    do_ar(16'h1104, 8'd0);
    total++;
    if ({rvalid_o, rdata_o, rresp_o, rlast_o} !== {1'b0, 32'h0, 2'b00, 1'b0}) begin
      bad++; $display("FAIL lat_idle rvalid=%b data=%h exp 0 0", rvalid_o, rdata_o);
    end
    @(negedge clk);
    total++;
    if ({rvalid_o, rdata_o, rresp_o, rlast_o} !== {1'b1, 32'h0, 2'b00, 1'b1}) begin
      bad++; $display("FAIL lat_first rvalid=%b data=%h resp=%b last=%b exp 1 0 00 1", rvalid_o, rdata_o, rresp_o, rlast_o);
    end
    rready_i = 1'b1;
    @(negedge clk);
    rready_i = 1'b0;
    total++;
    if (rvalid_o !== 1'b0) begin bad++; $display("FAIL lat_done rvalid=%b exp 0", rvalid_o); end
  endtask

  task automatic test_back_to_back();
    bit ok, rose; logic [31:0] d; logic [1:0] r; logic l;
    push(1'b1, 32'h71);
    arvalid_i = 1'b1; araddr_i = 16'h1100; arlen_i = 8'd1;
    @(negedge clk);
    total++;
    if (arready_o !== 1'b1) begin bad++; $display("FAIL b2b_second_ready got=%b exp=1", arready_o); end
    araddr_i = 16'h2000; arlen_i = 8'd0;
    @(negedge clk);
    araddr_i = 16'h1104; arlen_i = 8'd0;
    rose = 1'b0;
    repeat (3) begin if (arready_o !== 1'b0) rose = 1'b1; @(negedge clk); end
    total++;
    if (rose) begin bad++; $display("FAIL b2b_full arready rose=1 exp 0"); end
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, r, l} !== {1'b1, 32'h0, 2'b00, 1'b0}) begin bad++; $display("FAIL b2b_b1a data=%h last=%b exp 0 0", d, l); end
    total++;
    if ({rlast_o, arready_o} !== {1'b1, 1'b0}) begin
      bad++; $display("FAIL b2b_no_bypass rlast=%b arready=%b exp 1 0", rlast_o, arready_o);
    end
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, r, l} !== {1'b1, 32'h0, 2'b00, 1'b1}) begin bad++; $display("FAIL b2b_b1b data=%h last=%b exp 0 1", d, l); end
    total++;
    if (arready_o !== 1'b1) begin bad++; $display("FAIL b2b_reopen arready=%b exp 1", arready_o); end
    @(negedge clk);
    arvalid_i = 1'b0;
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, r, l} !== {1'b1, 32'h0, 2'b10, 1'b1}) begin bad++; $display("FAIL b2b_b2 data=%h resp=%b last=%b exp 0 10 1", d, r, l); end
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, r, l} !== {1'b1, 32'd1, 2'b00, 1'b1}) begin bad++; $display("FAIL b2b_b3 data=%h resp=%b last=%b exp 1 00 1", d, r, l); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [31:0] d; logic [1:0] r; logic l;
    do_ar(16'h2000, 8'd7);
    for (int b = 0; b < 3; b++) begin
      get_beat(ok, d, r, l);
      total++;
      if ({ok, r, l} !== {1'b1, 2'b10, 1'b0}) begin bad++; $display("FAIL rst_pre_beat%0d resp=%b last=%b exp 10 0", b, r, l); end
    end
    total++;
    if ({rvalid_o, vc_avail_o} !== {1'b1, 2'b10}) begin
      bad++; $display("FAIL rst_pre_state rvalid=%b avail=%b exp 1 10", rvalid_o, vc_avail_o);
    end
    arst = 1'b1;
    #1;
    total++;
    if ({rvalid_o, rlast_o, rresp_o, arready_o, vc_avail_o, in_ready_o} !== {1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1}) begin
      bad++; $display("FAIL rst_async rvalid=%b rlast=%b resp=%b arready=%b avail=%b exp 0 0 00 1 00",
                      rvalid_o, rlast_o, rresp_o, arready_o, vc_avail_o);
    end
    @(negedge clk);
    arst = 1'b0;
    do_ar(16'h2000, 8'd1);
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, r, l} !== {1'b1, 32'h0, 2'b10, 1'b0}) begin bad++; $display("FAIL rst_post_b0 resp=%b last=%b exp 10 0", r, l); end
    get_beat(ok, d, r, l);
    total++;
    if ({ok, d, r, l} !== {1'b1, 32'h0, 2'b10, 1'b1}) begin bad++; $display("FAIL rst_post_b1 resp=%b last=%b exp 10 1", r, l); end
  endtask

  initial begin
    arst = 1'b1;
    arvalid_i = 1'b0; araddr_i = '0; arlen_i = '0;
    rready_i = 1'b0;
    in_valid_i = 1'b0; in_vc_i = '0; in_data_i = '0;
    test_reset();
    test_vcbuf();
    test_stall();
    test_csr_full();
    test_push_pop();
    test_err();
    test_decode();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_vc_if.md
AXI_RD_VC_IF -- requirements
Module: axi_rd_vc_if

Interface
REQ-001 SHALL have parameter N_VC, default 2, number of virtual-channel receive buffers (>=1).
REQ-002 SHALL have parameter DATA_W, default 32, flit/AXI data width.
REQ-003 SHALL have parameter ADDR_W, default 16, decoded AXI address width.
REQ-004 SHALL have parameter BUF_DEPTH, default 4, slots per VC buffer (power of 2, >=2).
REQ-005 SHALL have parameter OT_DEPTH, default 2, outstanding read requests held (power of 2, >=2).
REQ-006 SHALL have parameter RD_BASE, default 'h1000, address of VC0 read buffer; VC i at RD_BASE+4*i.
REQ-007 SHALL have parameter CSR_BASE, default 'h1100, address of VC0 occupancy CSR; VC i at CSR_BASE+4*i.
REQ-008 clk  in  1  clock; all state on rising edge.
REQ-009 arst  in  1  reset, asynchronous, active-high.
REQ-010 arvalid/arready  in/out  1/1  AXI read-address handshake.
REQ-011 araddr  in  ADDR_W  read address; arlen  in  8  beats minus one.
REQ-012 rvalid/rready  out/in  1/1  AXI read-data handshake.
REQ-013 rdata  out  DATA_W; rresp  out  2; rlast  out  1.
REQ-014 in_valid/in_ready  in/out  1/1  flit push from packet side; in_vc  in  max(1,clog2(N_VC)); in_data  in  DATA_W.
REQ-015 vc_avail  out  N_VC  bit i = VC i buffer non-empty (registered state, no combinational input path).

Function
REQ-016 SHALL decode araddr at AR acceptance into region {VCBUF, CSR, ERR}, vc index and arlen, stored in an OT FIFO of OT_DEPTH entries.
REQ-017 Region VCBUF for RD_BASE+4*i, CSR for CSR_BASE+4*i, i<N_VC; every other address, incl. unaligned, is ERR.
REQ-018 arready SHALL equal ~ot_full; AR accepted when arvalid&arready.
REQ-019 Read FSM states IDLE, BURST; IDLE->BURST when OT non-empty (beat counter cleared to 0); BURST->IDLE on handshake of beat with rlast=1, popping OT entry that same edge.
REQ-020 AR accepted at edge N SHALL give earliest rvalid in the cycle after edge N+1; one IDLE cycle between consecutive bursts.
REQ-021 VCBUF: rvalid = ~empty[vc]; rdata = buffer head; rresp=OKAY; pop on rvalid&rready; burst stalls while buffer empty.
REQ-022 CSR: rvalid=1 every beat; rdata = occupancy of VC i zero-extended (width clog2(BUF_DEPTH+1)); rresp=OKAY; no buffer pop.
REQ-023 ERR: rvalid=1 every beat; rdata=0; rresp=SLVERR (2'b10); full arlen+1 beats returned.
REQ-024 rlast=1 only when rvalid=1 and beat counter == stored arlen; counter (8 bits) increments on each handshake, never wraps within a burst.
REQ-025 rdata/rresp/rlast SHALL hold stable while rvalid=1 and rready=0; rvalid SHALL not drop without handshake for CSR/ERR.
REQ-026 in_ready = ~full[in_vc]; push into buffer in_vc on in_valid&in_ready; no full-bypass (full buffer refuses push even if popping same cycle).
REQ-027 Simultaneous push and pop on same non-full, non-empty buffer SHALL keep occupancy unchanged and preserve FIFO order.
REQ-028 Simultaneous AR accept and OT pop with OT full: arready=0 that cycle (no bypass).
REQ-029 in_vc >= N_VC SHALL be dropped with in_ready=1.
REQ-030 Outside BURST: rvalid, rlast, rdata, rresp SHALL be 0.

Reset
REQ-031 arst SHALL asynchronously force FSM=IDLE, beat counter 0, OT FIFO and all VC buffers empty, including mid-burst.
REQ-032 During/after reset: arready=1, rvalid=0, rlast=0, rdata=0, rresp=0, in_ready=1, vc_avail=0.

Verification
REQ-033 Push 3 flits A,B,C to VC1; AR 'h1004 arlen=2, rready=1 -> rdata A,B,C OKAY, rlast on C, vc_avail[1]=0 after.
REQ-034 AR 'h1000 arlen=1 with VC0 empty; push D 5 cycles later, then E -> rvalid low until D present, beats D,E, rlast on E.
REQ-035 Push 4 flits VC0 (BUF_DEPTH=4) -> in_ready=0 for in_vc=0, 1 for in_vc=1; AR 'h1100 arlen=0 -> rdata=4, OKAY, rlast.
REQ-036 AR 'h2000 arlen=3 -> 4 beats rdata=0 rresp=2'b10, rlast on 4th; hold rready=0 2 cycles on beat 2 -> outputs stable.
REQ-037 Issue 3 ARs back-to-back with OT_DEPTH=2 -> arready low after 2 accepts until first burst's last handshake; bursts returned in order.
REQ-038 Assert arst mid-burst of arlen=7 after beat 3 -> rvalid=0 immediately, arready=1, vc_avail=0; new AR served normally after release.
